// File: rtl/icetap_readout_ctrl.sv
// Scan-clock sequencer: arms an icetap capture, then streams the captured window from the capture RAM.
// Define ICETAP_READOUT_HEADER_EN to prepend two header beats (window length, trigger offset).
module icetap_readout_ctrl #(
  parameter  int NR_SIGNALS   = 16,
  parameter  int RECORD_DEPTH = 256,
  localparam int ADDR_BITS    = $clog2(RECORD_DEPTH)
) (
  input  logic                  scan_clk,
  input  logic                  scan_reset_,
  input  logic                  host_arm,
  input  logic                  host_abort,
  output logic                  cap_start,
  input  logic [1:0]            cap_state,
  input  logic [ADDR_BITS-1:0]  cap_start_addr,
  input  logic [ADDR_BITS-1:0]  cap_trigger_addr,
  input  logic [ADDR_BITS-1:0]  cap_stop_addr,
  output logic                  mem_rd_ena,
  output logic [ADDR_BITS-1:0]  mem_rd_addr,
  input  logic [NR_SIGNALS-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NR_SIGNALS-1:0] out_data,
  output logic                  out_is_trigger,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int LEN_BITS = ADDR_BITS + 1;
  localparam int ENT_BITS = NR_SIGNALS + 2;  // {is_trigger, last, data}

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
`ifdef ICETAP_READOUT_HEADER_EN
    S_HDR     = 3'd3,
`endif
    S_READ    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  cap_start_q, cap_start_d;
  logic                  done_q, done_d;
  logic [ADDR_BITS-1:0]  trig_q, trig_d;
  logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic [LEN_BITS-1:0]   rd_left_q, rd_left_d;
  logic                  pend_q, pend_d;
  logic                  pend_trig_q, pend_trig_d;
  logic                  pend_last_q, pend_last_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic [ENT_BITS-1:0]   e0_q, e0_d;
  logic [ENT_BITS-1:0]   e1_q, e1_d;

  logic                  pop_s;
  logic                  issue_s;
  logic                  push_s;
  logic [ENT_BITS-1:0]   push_word_s;
  logic [2:0]            occ_s;
  logic [ADDR_BITS-1:0]  win_diff_s;
  logic [LEN_BITS-1:0]   win_len_s;

`ifdef ICETAP_READOUT_HEADER_EN
  logic [ADDR_BITS-1:0]  start_q, start_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic                  hdr_sel_q, hdr_sel_d;
  logic [ENT_BITS-1:0]   hdr_word_s;

  // Header payloads, zero-extended, never flagged as trigger or last.
  always_comb begin
    hdr_word_s = '0;
    if (!hdr_sel_q) begin
      hdr_word_s[LEN_BITS-1:0] = len_q;
    end else begin
      hdr_word_s[ADDR_BITS-1:0] = trig_q - start_q;
    end
  end
`endif

  // Next-state, RAM read issue and 2-entry skid FIFO.
  always_comb begin
    state_d     = state_q;
    cap_start_d = 1'b0;
    done_d      = done_q;
    trig_d      = trig_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    pend_d      = 1'b0;
    pend_trig_d = pend_trig_q;
    pend_last_d = pend_last_q;
    fifo_cnt_d  = fifo_cnt_q;
    e0_d        = e0_q;
    e1_d        = e1_q;
`ifdef ICETAP_READOUT_HEADER_EN
    start_d     = start_q;
    len_d       = len_q;
    hdr_sel_d   = hdr_sel_q;
`endif
    issue_s     = 1'b0;
    pop_s       = (fifo_cnt_q != 2'd0) && out_ready;
    // A beat leaving this cycle frees its slot, which keeps 1 beat/clk with only 2 entries.
    occ_s       = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, pop_s};
    push_s      = pend_q;
    push_word_s = {pend_trig_q, pend_last_q, mem_rd_data};
    win_diff_s  = cap_stop_addr - cap_start_addr;
    win_len_s   = (win_diff_s == '0) ? LEN_BITS'(RECORD_DEPTH) : {1'b0, win_diff_s};

    case (state_q)
      S_IDLE: begin
        if (host_arm) begin
          cap_start_d = 1'b1;
          done_d      = 1'b0;
          state_d     = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (cap_state != 2'd0) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_ARM;
        end
      end
      S_CAPTURE: begin
        if (cap_state == 2'd0) begin
          trig_d    = cap_trigger_addr;
          rd_addr_d = cap_start_addr;
          rd_left_d = win_len_s;
`ifdef ICETAP_READOUT_HEADER_EN
          start_d   = cap_start_addr;
          len_d     = win_len_s;
          hdr_sel_d = 1'b0;
          state_d   = S_HDR;
`else
          state_d   = S_READ;
`endif
        end else begin
          state_d = S_CAPTURE;
        end
      end
`ifdef ICETAP_READOUT_HEADER_EN
      S_HDR: begin
        if (occ_s < 3'd2) begin
          push_s      = 1'b1;
          push_word_s = hdr_word_s;
          hdr_sel_d   = 1'b1;
          state_d     = hdr_sel_q ? S_READ : S_HDR;
        end else begin
          state_d = S_HDR;
        end
      end
`endif
      S_READ: begin
        if ((rd_left_q != '0) && (occ_s < 3'd2)) begin
          issue_s     = 1'b1;
          pend_d      = 1'b1;
          pend_trig_d = (rd_addr_q == trig_q);
          pend_last_d = (rd_left_q == LEN_BITS'(1));
          rd_addr_d   = rd_addr_q + ADDR_BITS'(1);
          rd_left_d   = rd_left_q - LEN_BITS'(1);
        end else begin
          issue_s = 1'b0;
        end
        if (pop_s && e0_q[NR_SIGNALS]) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (fifo_cnt_q)
      2'd0: begin
        if (push_s) begin
          e0_d       = push_word_s;
          fifo_cnt_d = 2'd1;
        end else begin
          fifo_cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          e0_d = push_word_s;
        end else if (push_s) begin
          e1_d       = push_word_s;
          fifo_cnt_d = 2'd2;
        end else if (pop_s) begin
          fifo_cnt_d = 2'd0;
        end else begin
          fifo_cnt_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          e0_d = e1_q;
          if (push_s) begin
            e1_d = push_word_s;
          end else begin
            fifo_cnt_d = 2'd1;
          end
        end else begin
          fifo_cnt_d = 2'd2;
        end
      end
      default: fifo_cnt_d = 2'd0;
    endcase

    // Abort beats everything, including a simultaneous arm; the capture block keeps running.
    if (host_abort) begin
      state_d     = S_IDLE;
      cap_start_d = 1'b0;
      done_d      = 1'b0;
      pend_d      = 1'b0;
      fifo_cnt_d  = 2'd0;
      rd_left_d   = '0;
      issue_s     = 1'b0;
    end else begin
      pend_d = pend_d;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge scan_clk) begin
    if (!scan_reset_) begin
      state_q     <= S_IDLE;
      cap_start_q <= 1'b0;
      done_q      <= 1'b0;
      trig_q      <= '0;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      pend_q      <= 1'b0;
      pend_trig_q <= 1'b0;
      pend_last_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      e0_q        <= '0;
      e1_q        <= '0;
`ifdef ICETAP_READOUT_HEADER_EN
      start_q     <= '0;
      len_q       <= '0;
      hdr_sel_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cap_start_q <= cap_start_d;
      done_q      <= done_d;
      trig_q      <= trig_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      pend_q      <= pend_d;
      pend_trig_q <= pend_trig_d;
      pend_last_q <= pend_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
`ifdef ICETAP_READOUT_HEADER_EN
      start_q     <= start_d;
      len_q       <= len_d;
      hdr_sel_q   <= hdr_sel_d;
`endif
    end
  end

  assign cap_start      = cap_start_q;
  assign mem_rd_ena     = issue_s;
  assign mem_rd_addr    = issue_s ? rd_addr_q : '0;
  assign out_valid      = (fifo_cnt_q != 2'd0);
  assign out_data       = out_valid ? e0_q[NR_SIGNALS-1:0] : '0;
  assign out_last       = out_valid & e0_q[NR_SIGNALS];
  assign out_is_trigger = out_valid & e0_q[NR_SIGNALS+1];
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

endmodule
